// File: rtl/dac714_pkg.sv
// Shared types and limits for the DAC714 serial shifter.
package dac714_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } dacState_t;

    localparam int CLK_DIV_MIN = 1;
    localparam int CLK_DIV_MAX = 255;
    localparam int CNT_WIDTH   = 8;

endpackage

// File: rtl/dac714_sclk_gen.sv
// SCLK phase generator: holds sclk low while idle, then alternates CLK_DIV-cycle low/high phases
// and flags the last cycle of each phase so the shifter can act on the coming edge.
module dac714_sclk_gen
    import dac714_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_slow,
    input  logic nReset,
    input  logic i_run,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_phase;
    logic                 w_phaseEnd;

    if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_badClkDiv
        $error("dac714_sclk_gen: CLK_DIV out of range");
    end

    assign w_phaseEnd = (r_count == CNT_WIDTH'(CLK_DIV - 1));

    // Counter restarts from a low phase every time a frame begins shifting
    always_ff @(posedge clk_slow) begin
        if (!nReset || !i_run) begin
            r_count <= '0;
            r_phase <= 1'b0;
        end else if (w_phaseEnd) begin
            r_count <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_sclk = r_phase;
    assign o_rise = i_run && w_phaseEnd && !r_phase;
    assign o_fall = i_run && w_phaseEnd && r_phase;

endmodule

// File: rtl/dac714_shift_out.sv
// DAC714 serial shifter: captures a sample on a strobe edge, shifts it out MSB first, then pulses the A1 latch.
// Define DAC714_PEND_EN to add a one-deep pending buffer that chains frames back to back.
module dac714_shift_out
    import dac714_pkg::*;
#(
    parameter int DAC_WIDTH = 16,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk_slow,
    input  logic                 nReset,
    input  logic                 strobe,
    input  logic [DAC_WIDTH-1:0] data,
    input  logic                 ovr_clr,
    output logic                 dac_sclk,
    output logic                 dac_sdi,
    output logic                 dac_nlatch,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int BIT_CNT_W = $clog2(DAC_WIDTH + 1);

    dacState_t              r_state;
    dacState_t              w_nextState;
    logic                   r_strobePrev;
    logic                   w_strobeEdge;
    logic [DAC_WIDTH-1:0]   r_shift;
    logic [BIT_CNT_W-1:0]   r_bitCount;
    logic [CNT_WIDTH-1:0]   r_latchCount;
    logic                   r_overrun;
    logic                   w_sclk;
    logic                   w_sclkRise;
    logic                   w_sclkFall;
    logic                   w_lastBit;
    logic                   w_latchEnd;
    logic                   w_load;
    logic [DAC_WIDTH-1:0]   w_loadWord;
    logic                   w_setOverrun;

    dac714_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclkGen (
        .clk_slow (clk_slow),
        .nReset   (nReset),
        .i_run    (r_state == SHIFT),
        .o_sclk   (w_sclk),
        .o_rise   (w_sclkRise),
        .o_fall   (w_sclkFall)
    );

    assign w_strobeEdge = strobe && !r_strobePrev;
    assign w_lastBit    = (r_bitCount == BIT_CNT_W'(DAC_WIDTH));
    assign w_latchEnd   = (r_latchCount == CNT_WIDTH'(CLK_DIV - 1));

`ifdef DAC714_PEND_EN
    logic                 r_pendValid;
    logic [DAC_WIDTH-1:0] r_pendData;
    logic                 w_takePend;
    logic                 w_direct;
    logic                 w_bufWrite;

    assign w_takePend   = (r_state == GAP) && r_pendValid;
    assign w_direct     = w_strobeEdge && ((r_state == IDLE) || ((r_state == GAP) && !r_pendValid));
    assign w_bufWrite   = w_strobeEdge && !w_direct;
    assign w_load       = w_takePend || w_direct;
    assign w_loadWord   = w_takePend ? r_pendData : data;
    // The buffer only counts as full when GAP is not draining it in this same cycle
    assign w_setOverrun = w_bufWrite && r_pendValid && !w_takePend;

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            r_pendValid <= 1'b0;
            r_pendData  <= '0;
        end else if (w_bufWrite) begin
            r_pendValid <= 1'b1;
            r_pendData  <= data;
        end else if (w_takePend) begin
            r_pendValid <= 1'b0;
        end
    end
`else
    assign w_load       = w_strobeEdge && (r_state == IDLE);
    assign w_loadWord   = data;
    assign w_setOverrun = w_strobeEdge && (r_state != IDLE);
`endif

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_strobePrev <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_strobePrev <= strobe;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:  if (w_load) w_nextState = SHIFT;
            SHIFT: if (w_sclkFall && w_lastBit) w_nextState = LATCH;
            LATCH: if (w_latchEnd) w_nextState = GAP;
            GAP:   w_nextState = w_load ? SHIFT : IDLE;
        endcase
    end

    always_comb begin
        dac_sclk   = 1'b0;
        dac_sdi    = 1'b0;
        dac_nlatch = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (r_state)
            IDLE:  busy = 1'b0;
            SHIFT: begin
                dac_sclk = w_sclk;
                dac_sdi  = r_shift[DAC_WIDTH-1];
            end
            LATCH: dac_nlatch = 1'b0;
            GAP:   done = 1'b1;
        endcase
    end

    // Bits are counted on sclk rises; the next MSB is presented as sclk falls
    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            r_shift      <= '0;
            r_bitCount   <= '0;
            r_latchCount <= '0;
        end else begin
            if (w_load) begin
                r_shift    <= w_loadWord;
                r_bitCount <= '0;
            end else if (r_state == SHIFT) begin
                if (w_sclkRise) r_bitCount <= r_bitCount + BIT_CNT_W'(1);
                if (w_sclkFall) r_shift <= {r_shift[DAC_WIDTH-2:0], 1'b0};
            end
            if (r_state == LATCH) r_latchCount <= r_latchCount + CNT_WIDTH'(1);
            else                  r_latchCount <= '0;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (!nReset)           r_overrun <= 1'b0;
        else if (w_setOverrun) r_overrun <= 1'b1;
        else if (ovr_clr)      r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;

endmodule
